runway_scheduler: RTL and testbench

RUNWAY_SCHEDULER -- requirements
Module: runway_scheduler

---
 rtl/runway_scheduler.sv | 129 ++++++++++++
 tb/tb_runway_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/runway_scheduler.sv
// Two-runway clearance scheduler: picks landing/takeoff requests onto free runways,
// tracks runway ownership, validates releases and force-frees runways on timeout.
module runway_scheduler #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       takeoff_req,
  input  logic [3:0] takeoff_id,
  input  logic       landing_req,
  input  logic [3:0] landing_id,
  input  logic       emergency,
  input  logic       release_valid,
  input  logic       release_runway,
  input  logic [3:0] release_id,
  input  logic       grant_ready,
  output logic       takeoff_ack,
  output logic       landing_ack,
  output logic       grant_valid,
  output logic [3:0] grant_id,
  output logic       grant_runway,
  output logic       grant_landing,
  output logic [1:0] runway_active,
  output logic [3:0] owner0_id,
  output logic [3:0] owner1_id,
  output logic       release_error,
  output logic [1:0] timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             last_landing;
  logic [CNT_W-1:0] cnt0, cnt1;

  logic       land_el, to_el, pick, pick_landing, pick_rw, rel_hit;
  logic [1:0] rel_ok, expire;

  always_comb begin
    land_el      = landing_req;
    to_el        = takeoff_req & ~emergency;
    pick         = (state == IDLE) && !(&runway_active) && (land_el || to_el);
    // On a tie, grant whichever type was not granted last.
    pick_landing = land_el && (!to_el || !last_landing);
    pick_rw      = runway_active[0];
    rel_hit      = release_valid && runway_active[release_runway] &&
                   (release_id == (release_runway ? owner1_id : owner0_id));
    rel_ok       = {rel_hit & release_runway, rel_hit & ~release_runway};
    // A valid release at the final count wins over the forced release.
    expire[0]    = runway_active[0] && (cnt0 == CNT_LAST) && !rel_ok[0];
    expire[1]    = runway_active[1] && (cnt1 == CNT_LAST) && !rel_ok[1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      last_landing  <= 1'b0;
      cnt0          <= '0;
      cnt1          <= '0;
      takeoff_ack   <= 1'b0;
      landing_ack   <= 1'b0;
      grant_valid   <= 1'b0;
      grant_id      <= '0;
      grant_runway  <= 1'b0;
      grant_landing <= 1'b0;
      runway_active <= '0;
      owner0_id     <= '0;
      owner1_id     <= '0;
      release_error <= 1'b0;
      timeout       <= '0;
    end else begin
      takeoff_ack   <= 1'b0;
      landing_ack   <= 1'b0;
      release_error <= release_valid && !rel_hit;
      timeout       <= expire;

      if (runway_active[0]) begin
        if (rel_ok[0] || expire[0]) begin
          runway_active[0] <= 1'b0;
          cnt0             <= '0;
        end else begin
          cnt0 <= cnt0 + CNT_W'(1);
        end
      end else begin
        cnt0 <= '0;
      end

      if (runway_active[1]) begin
        if (rel_ok[1] || expire[1]) begin
          runway_active[1] <= 1'b0;
          cnt1             <= '0;
        end else begin
          cnt1 <= cnt1 + CNT_W'(1);
        end
      end else begin
        cnt1 <= '0;
      end

      case (state)
        IDLE: begin
          if (pick) begin
            state                  <= GRANT;
            grant_valid            <= 1'b1;
            grant_id               <= pick_landing ? landing_id : takeoff_id;
            grant_runway           <= pick_rw;
            grant_landing          <= pick_landing;
            last_landing           <= pick_landing;
            landing_ack            <= pick_landing;
            takeoff_ack            <= !pick_landing;
            runway_active[pick_rw] <= 1'b1;
            if (pick_rw) owner1_id <= pick_landing ? landing_id : takeoff_id;
            else         owner0_id <= pick_landing ? landing_id : takeoff_id;
          end
        end
        GRANT: begin
          if (grant_ready) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_runway_scheduler.sv
// Directed bench for runway_scheduler with TIMEOUT=8; inputs change and outputs are
// sampled on the falling clock edge.
module tb_runway_scheduler;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       takeoff_req, landing_req, emergency;
  logic [3:0] takeoff_id, landing_id, release_id;
  logic       release_valid, release_runway, grant_ready;
  logic       takeoff_ack, landing_ack, grant_valid, grant_runway, grant_landing;
  logic [3:0] grant_id, owner0_id, owner1_id;
  logic [1:0] runway_active, timeout;
  logic       release_error;

  int tests = 0;
  int fails = 0;

  runway_scheduler #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .takeoff_req(takeoff_req), .takeoff_id(takeoff_id),
    .landing_req(landing_req), .landing_id(landing_id),
    .emergency(emergency),
    .release_valid(release_valid), .release_runway(release_runway), .release_id(release_id),
    .grant_ready(grant_ready),
    .takeoff_ack(takeoff_ack), .landing_ack(landing_ack),
    .grant_valid(grant_valid), .grant_id(grant_id), .grant_runway(grant_runway),
    .grant_landing(grant_landing), .runway_active(runway_active),
    .owner0_id(owner0_id), .owner1_id(owner1_id),
    .release_error(release_error), .timeout(timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".outs"}, {takeoff_ack, landing_ack, grant_valid, grant_id, grant_runway,
                         grant_landing, runway_active, owner0_id, owner1_id,
                         release_error, timeout}, 32'h0);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    takeoff_req = 0; takeoff_id = 0; landing_req = 0; landing_id = 0; emergency = 0;
    release_valid = 0; release_runway = 0; release_id = 0; grant_ready = 1;
    #3 chk_all_zero("reset0");
    step(); step();
    chk_all_zero("reset1");
    reset_n = 1'b1;

    // Single takeoff onto runway 0, then bad and good releases.
    takeoff_req = 1; takeoff_id = 4'd3;
    step();
    chk("t1.tack", takeoff_ack, 1);
    chk("t1.lack", landing_ack, 0);
    chk("t1.gv", grant_valid, 1);
    chk("t1.gid", grant_id, 3);
    chk("t1.grw", grant_runway, 0);
    chk("t1.gland", grant_landing, 0);
    chk("t1.active", runway_active, 2'b01);
    chk("t1.owner0", owner0_id, 3);
    takeoff_req = 0;
    step();
    chk("t1.tack_off", takeoff_ack, 0);
    chk("t1.gv_off", grant_valid, 0);
    release_valid = 1; release_runway = 0; release_id = 4'd7;
    step();
    chk("rel.err", release_error, 1);
    chk("rel.err_active", runway_active, 2'b01);
    release_id = 4'd3;
    step();
    chk("rel.ok_err", release_error, 0);
    chk("rel.ok_active", runway_active, 2'b00);
    release_valid = 0;

    // Landing and takeoff both pending: landing first, takeoff onto runway 1.
    takeoff_req = 1; takeoff_id = 4'd2; landing_req = 1; landing_id = 4'd5;
    step();
    chk("tie.lack", landing_ack, 1);
    chk("tie.tack", takeoff_ack, 0);
    chk("tie.gid", grant_id, 5);
    chk("tie.gland", grant_landing, 1);
    chk("tie.grw", grant_runway, 0);
    landing_req = 0;
    step();
    chk("tie.gap_gv", grant_valid, 0);
    step();
    chk("tie2.tack", takeoff_ack, 1);
    chk("tie2.gid", grant_id, 2);
    chk("tie2.grw", grant_runway, 1);
    chk("tie2.gland", grant_landing, 0);
    chk("tie2.active", runway_active, 2'b11);
    chk("tie2.owner1", owner1_id, 2);
    takeoff_req = 0;
    release_valid = 1; release_runway = 0; release_id = 4'd5;
    step();
    chk("tie.rel0", runway_active, 2'b10);
    release_runway = 1; release_id = 4'd2;
    step();
    chk("tie.rel1", runway_active, 2'b00);
    release_valid = 0;

    // Emergency blocks takeoff; landing still cleared.
    emergency = 1; takeoff_req = 1; takeoff_id = 4'd4;
    step(); step(); step();
    chk("emg.tack", takeoff_ack, 0);
    chk("emg.gv", grant_valid, 0);
    chk("emg.active", runway_active, 2'b00);
    landing_req = 1; landing_id = 4'd6;
    step();
    chk("emg.lack", landing_ack, 1);
    chk("emg.tack2", takeoff_ack, 0);
    chk("emg.gid", grant_id, 6);
    chk("emg.gland", grant_landing, 1);
    landing_req = 0;
    step();
    emergency = 0; takeoff_req = 0;
    release_valid = 1; release_runway = 0; release_id = 4'd6;
    step();
    chk("emg.rel", runway_active, 2'b00);
    release_valid = 0;

    // Lock runways 0 then 1; runway 0 released at its last count, runway 1 times out.
    landing_req = 1; landing_id = 4'd1;
    step();
    chk("to.lock0", runway_active, 2'b01);
    landing_id = 4'd9;
    step();
    step();
    chk("to.lock1_rw", grant_runway, 1);
    chk("to.lock1", runway_active, 2'b11);
    landing_req = 0;
    for (int k = 3; k <= 11; k++) begin
      step();
      chk($sformatf("to.active%0d", k), runway_active, (k < 8) ? 2'b11 : (k < 10) ? 2'b10 : 2'b00);
      chk($sformatf("to.pulse%0d", k), timeout, (k == 10) ? 2'b10 : 2'b00);
      if (k == 7) begin
        release_valid = 1; release_runway = 0; release_id = 4'd1;
      end
      if (k == 8) release_valid = 0;
    end

    // Emergency rising during GRANT keeps the grant; reset then clears everything.
    grant_ready = 0; takeoff_req = 1; takeoff_id = 4'd4;
    step();
    chk("eg.tack", takeoff_ack, 1);
    emergency = 1; takeoff_req = 0;
    step();
    chk("eg.gv", grant_valid, 1);
    chk("eg.gid", grant_id, 4);
    chk("eg.gland", grant_landing, 0);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("rst.async");
    emergency = 0;
    step();
    chk_all_zero("rst.hold");
    reset_n = 1'b1;
    step();
    chk("rst.idle_gv", grant_valid, 0);
    grant_ready = 1; takeoff_req = 1; takeoff_id = 4'd8; landing_req = 1; landing_id = 4'd13;
    step();
    chk("rst.lack", landing_ack, 1);
    chk("rst.gid", grant_id, 13);
    chk("rst.active", runway_active, 2'b01);
    landing_req = 0; takeoff_req = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
